period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Measures the period of a free-running input clock (PLL reference) by counting cycles of a fast sampling clock.
//  Produces the ref_period_1000 / period_stable pair that the PLL frequency generators consume.
//  Sits at the PLL input, upstream of the frequency generators; fully synchronous to clk, synthesizable.
// PARAMETERS
//  CLK_PERIOD_1000  1000  sampling clk period in ns*1000 (ps); scale factor for all *_1000 outputs
//  CNT_W            24    width of cycle counters
//  TOL              1     max |new - ref| in clk cycles still counted as a match
//  STABLE_CNT       4     consecutive matches required to assert period_stable
//  TIMEOUT_CYC      4096  clk cycles without a rising edge -> measurement lost; must be < 2**CNT_W
// PORTS
//  clk             in   1   sampling clock; all state on posedge
//  RST_N           in   1   asynchronous, active-low reset
//  PWRDWN          in   1   synchronous power-down; holds block in IDLE
//  meas_in         in   1   clock under measurement, asynchronous to clk
//  period_1000     out  32  measured period, ns*1000
//  period_stable   out  1   period_1000 is trustworthy
//  high_time_1000  out  32  high phase of meas_in, ns*1000 (only with DUTY_MEAS_EN)
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=IDLE; all counters, period_1000, period_stable, high_time_1000 = 0.
//  - meas_in -> 2-FF synchronizer -> meas_s; rise = meas_s & ~meas_d (one-cycle pulse).
//  - cnt: on rise cnt<=1, else cnt<=cnt+1 (saturates at 2**CNT_W-1); captured value = cycles between rises.
//  - period_1000 <= sat32(captured*CLK_PERIOD_1000) on every capture from ARM onward; visible cycle after rise.
//  - FSM:
//    IDLE:   cnt held 0; on rise -> ARM (cnt<=1).
//    ARM:    on rise: ref<=cnt, match<=0 -> TRACK.
//    TRACK:  on rise: |cnt-ref|<=TOL -> match++; if match+1==STABLE_CNT -> LOCKED, period_stable<=1.
//            mismatch -> ref<=cnt, match<=0, stay.
//    LOCKED: on rise within TOL: ref<=cnt, stay; mismatch: ref<=cnt, match<=0, period_stable<=0 -> TRACK.
//  - Timeout: in ARM/TRACK/LOCKED, cnt==TIMEOUT_CYC with no rise -> IDLE, period_stable<=0, period_1000<=0.
//  - Rise and timeout in same cycle: rise wins (period of exactly TIMEOUT_CYC is valid).
//  - PWRDWN=1: next cycle state=IDLE, outputs 0, rises ignored; release -> normal from IDLE.
//  - period_stable only ever asserted in LOCKED; deasserts in the same cycle the FSM leaves LOCKED.
//  - Multiply uses 64-bit intermediate; result > 2**32-1 saturates to 32'hFFFF_FFFF.
// CONFIGURATION
//  - Macro PERIOD_METER_DUTY_MEAS_EN:
//    defined: high_cnt counts cycles with meas_s=1 since last rise; on capture high_time_1000 <= sat32(high_cnt*CLK_PERIOD_1000),
//    high_cnt<=0 (or 1 if meas_s still high); reset/IDLE/PWRDWN -> 0; port present.
//    undefined: high_cnt logic and high_time_1000 port absent; all other behaviour identical.
// STRUCTURE
//  - Shared include pll_defs.vh: FSM state localparams (IDLE/ARM/TRACK/LOCKED), SAT32 constant, abs-diff macro.
//  - Sub-module sync_edge_det: 2-FF synchronizer + rising-edge pulse, async active-low reset; reused elsewhere in the PLL.
// TESTING (clk 1 ns, CLK_PERIOD_1000=1000, TOL=1, STABLE_CNT=4, TIMEOUT_CYC=64 unless noted)
//  1. meas_in 10 ns period, 50% duty -> period_1000=10000; period_stable=1 the cycle after the 6th detected rise.
//  2. Locked at 10 ns, switch to 14 ns -> stable drops after first 14-cycle capture, period_1000=14000, relock after 4 more matches.
//  3. Periods alternating 10/11 ns -> all captures within TOL, period_stable stays 1, period_1000 tracks 10000/11000.
//  4. Stop meas_in while locked -> 64 cycles after last rise: period_stable=0, period_1000=0, FSM IDLE; restart relocks as in 1.
//  5. RST_N low mid-LOCKED -> period_stable/period_1000 = 0 immediately (before next clk); PWRDWN=1 pulse -> same, synchronously.
//  6. PERIOD_METER_DUTY_MEAS_EN defined, 10 ns at 30% duty -> high_time_1000=3000; undefined build elaborates without the port.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the PLL reference period meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } pm_state_e;

    localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;

    // Clamp a 64-bit product into the 32-bit *_1000 output range.
    function automatic logic [31:0] sat32(input logic [63:0] v);
        return (v > 64'(SAT32)) ? SAT32 : v[31:0];
    endfunction

    function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus one-cycle rising-edge pulse for an asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic level,
    output logic rise_c
);

    logic ff1;
    logic ff2;
    logic ff3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
            ff3 <= 1'b0;
        end else begin
            ff1 <= d_async;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign level  = ff2;
    assign rise_c = ff2 & ~ff3;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the meas_in period in clk cycles and flags when it has settled.
// Optional high-phase measurement enabled by defining PERIOD_METER_DUTY_MEAS_EN.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_1000 = 1000,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned TOL             = 1,
    parameter int unsigned STABLE_CNT      = 4,
    parameter int unsigned TIMEOUT_CYC     = 4096
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        PWRDWN,
    input  logic        meas_in,
    output logic [31:0] period_1000,
    output logic        period_stable
`ifdef PERIOD_METER_DUTY_MEAS_EN
    ,
    output logic [31:0] high_time_1000
`endif
);

    localparam int unsigned MATCH_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pm_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    ref_cnt;
    logic [MATCH_W-1:0]  match;
    logic                meas_s;
    logic                rise;
    logic                in_tol;
    logic                match_last;
    logic                timeout;
    logic [CNT_W-1:0]    cnt_inc;
    logic [63:0]         period_prod;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst_n   (RST_N),
        .d_async (meas_in),
        .level   (meas_s),
        .rise_c  (rise)
    );

    assign in_tol      = abs_diff(64'(cnt), 64'(ref_cnt)) <= 64'(TOL);
    assign match_last  = (32'(match) + 32'd1) == 32'(STABLE_CNT);
    assign timeout     = cnt == CNT_W'(TIMEOUT_CYC);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign period_prod = 64'(cnt) * 64'(CLK_PERIOD_1000);

    // Measurement FSM; a rise in the timeout cycle is still a valid capture.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ref_cnt       <= '0;
            match         <= '0;
            period_1000   <= '0;
            period_stable <= 1'b0;
        end else if (PWRDWN) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ref_cnt       <= '0;
            match         <= '0;
            period_1000   <= '0;
            period_stable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_ARM;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (rise) begin
                        cnt         <= CNT_W'(1);
                        period_1000 <= sat32(period_prod);
                        case (state)
                            ST_ARM: begin
                                ref_cnt <= cnt;
                                match   <= '0;
                                state   <= ST_TRACK;
                            end
                            ST_TRACK: begin
                                if (in_tol) begin
                                    match <= match + MATCH_W'(1);
                                    if (match_last) begin
                                        state         <= ST_LOCKED;
                                        period_stable <= 1'b1;
                                    end
                                end else begin
                                    ref_cnt <= cnt;
                                    match   <= '0;
                                end
                            end
                            ST_LOCKED: begin
                                ref_cnt <= cnt;
                                if (!in_tol) begin
                                    match         <= '0;
                                    period_stable <= 1'b0;
                                    state         <= ST_TRACK;
                                end
                            end
                            default: ;
                        endcase
                    end else if (timeout) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        period_1000   <= '0;
                        period_stable <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

`ifdef PERIOD_METER_DUTY_MEAS_EN
    logic [CNT_W-1:0] high_cnt;
    logic [63:0]      high_prod;

    assign high_prod = 64'(high_cnt) * 64'(CLK_PERIOD_1000);

    // High-phase counter restarts at each rise, counting the rise cycle itself.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            high_cnt       <= '0;
            high_time_1000 <= '0;
        end else if (PWRDWN) begin
            high_cnt       <= '0;
            high_time_1000 <= '0;
        end else if (state == ST_IDLE) begin
            high_cnt       <= rise ? CNT_W'(1) : '0;
            high_time_1000 <= '0;
        end else if (rise) begin
            high_time_1000 <= sat32(high_prod);
            high_cnt       <= CNT_W'(meas_s);
        end else if (timeout) begin
            high_cnt       <= '0;
            high_time_1000 <= '0;
        end else if (meas_s && (high_cnt != CNT_MAX)) begin
            high_cnt <= high_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_meas_s;
    assign unused_meas_s = meas_s;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Randomized bench for period_meter against an elapsed-time reference model.
module tb_period_meter;

    localparam int unsigned CLKP = 1000;
    localparam int unsigned TOLV = 1;
    localparam int unsigned STAB = 4;
    localparam int unsigned TMO  = 64;

    localparam int S_IDLE   = 0;
    localparam int S_ARM    = 1;
    localparam int S_TRACK  = 2;
    localparam int S_LOCKED = 3;

    logic        clk;
    logic        RST_N;
    logic        PWRDWN;
    logic        meas_in;
    logic [31:0] period_1000;
    logic        period_stable;
`ifdef PERIOD_METER_DUTY_MEAS_EN
    logic [31:0] high_time_1000;
`endif

    int checks = 0;
    int errors = 0;
    logic rst_drv;

    // Reference model state: time is measured in processed clk edges.
    longint      cyc;
    longint      last_rise;
    longint      ref_len;
    logic        h [4];
    int          m_state;
    int          m_match;
    int          m_hi;
    logic [31:0] m_per;
    logic [31:0] m_ht;
    logic        m_stb;

    period_meter #(
        .CLK_PERIOD_1000 (CLKP),
        .CNT_W           (24),
        .TOL             (TOLV),
        .STABLE_CNT      (STAB),
        .TIMEOUT_CYC     (TMO)
    ) dut (
        .clk            (clk),
        .RST_N          (RST_N),
        .PWRDWN         (PWRDWN),
        .meas_in        (meas_in),
        .period_1000    (period_1000),
        .period_stable  (period_stable)
`ifdef PERIOD_METER_DUTY_MEAS_EN
        ,
        .high_time_1000 (high_time_1000)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_ps(input longint c);
        longint v;
        v = c * longint'(CLKP);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) h[i] = 1'b0;
        m_state   = S_IDLE;
        m_match   = 0;
        m_hi      = 0;
        m_per     = '0;
        m_ht      = '0;
        m_stb     = 1'b0;
        ref_len   = 0;
        last_rise = 0;
    endtask

    // One clk edge as seen by the design: meas_in reaches the edge detector two edges late.
    task automatic model_step();
        logic   r;
        longint el;
        longint diff;
        h[3] = h[2];
        h[2] = h[1];
        h[1] = h[0];
        h[0] = meas_in;
        r  = h[2] && !h[3];
        el = cyc - last_rise;
        if (PWRDWN) begin
            m_state = S_IDLE;
            m_per   = '0;
            m_stb   = 1'b0;
            m_ht    = '0;
            m_hi    = 0;
        end else if (m_state == S_IDLE) begin
            m_ht = '0;
            m_hi = r ? 1 : 0;
            if (r) begin
                m_state   = S_ARM;
                last_rise = cyc;
            end
        end else if (r) begin
            m_per     = to_ps(el);
            m_ht      = to_ps(longint'(m_hi));
            m_hi      = 1;
            last_rise = cyc;
            diff      = (el > ref_len) ? el - ref_len : ref_len - el;
            if (m_state == S_ARM) begin
                ref_len = el;
                m_match = 0;
                m_state = S_TRACK;
            end else if (m_state == S_TRACK) begin
                if (diff <= longint'(TOLV)) begin
                    m_match++;
                    if (m_match == int'(STAB)) begin
                        m_state = S_LOCKED;
                        m_stb   = 1'b1;
                    end
                end else begin
                    ref_len = el;
                    m_match = 0;
                end
            end else begin
                ref_len = el;
                if (diff > longint'(TOLV)) begin
                    m_match = 0;
                    m_stb   = 1'b0;
                    m_state = S_TRACK;
                end
            end
        end else if (el == longint'(TMO)) begin
            m_state = S_IDLE;
            m_per   = '0;
            m_stb   = 1'b0;
            m_ht    = '0;
            m_hi    = 0;
        end else begin
            m_hi += int'(h[2]);
        end
        cyc++;
    endtask

    task automatic cycle(input logic m, input logic pd);
        @(negedge clk);
        meas_in = m;
        PWRDWN  = pd;
        RST_N   = rst_drv;
        @(posedge clk);
        #1;
        if (!RST_N) model_reset();
        else model_step();
        chk("period", period_1000, m_per);
        chk("stable", {31'b0, period_stable}, {31'b0, m_stb});
`ifdef PERIOD_METER_DUTY_MEAS_EN
        chk("high_time", high_time_1000, m_ht);
`endif
    endtask

    task automatic run(input int p, input int hi, input int n, input bit jit);
        int pp;
        for (int k = 0; k < n; k++) begin
            pp = p + (jit ? int'($urandom_range(0, 1)) : 0);
            for (int i = 0; i < pp; i++) cycle(i < hi, 1'b0);
        end
    endtask

    initial begin
        int p;
        int hi;
        RST_N   = 1'b0;
        rst_drv = 1'b0;
        PWRDWN  = 1'b0;
        meas_in = 1'b0;
        cyc     = 0;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        chk("reset_period", period_1000, 32'd0);
        chk("reset_stable", {31'b0, period_stable}, 32'd0);
        rst_drv = 1'b1;

        run(10, 5, 8, 1'b0);
        chk("lock10_stable", {31'b0, period_stable}, 32'd1);
        chk("lock10_period", period_1000, 32'd10000);

        run(14, 7, 8, 1'b0);
        chk("lock14_stable", {31'b0, period_stable}, 32'd1);
        chk("lock14_period", period_1000, 32'd14000);

        for (int i = 0; i < 6; i++) begin
            run(10, 5, 1, 1'b0);
            run(11, 5, 1, 1'b0);
        end
        chk("alt_stable", {31'b0, period_stable}, 32'd1);
        chk("alt_period", period_1000, 32'd10000);

        for (int i = 0; i < 80; i++) cycle(1'b0, 1'b0);
        chk("timeout_stable", {31'b0, period_stable}, 32'd0);
        chk("timeout_period", period_1000, 32'd0);

        run(10, 3, 8, 1'b0);
        chk("relock_stable", {31'b0, period_stable}, 32'd1);
        chk("relock_period", period_1000, 32'd10000);
`ifdef PERIOD_METER_DUTY_MEAS_EN
        chk("duty30_high", high_time_1000, 32'd3000);
`endif

        // Asynchronous reset lands between clock edges.
        #1;
        RST_N   = 1'b0;
        rst_drv = 1'b0;
        #1;
        chk("rst_async_period", period_1000, 32'd0);
        chk("rst_async_stable", {31'b0, period_stable}, 32'd0);
        model_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst_drv = 1'b1;

        run(10, 5, 8, 1'b0);
        cycle(1'b1, 1'b1);
        chk("pwrdwn_period", period_1000, 32'd0);
        chk("pwrdwn_stable", {31'b0, period_stable}, 32'd0);
        cycle(1'b0, 1'b1);
        run(10, 5, 8, 1'b0);
        chk("pwrdwn_relock", {31'b0, period_stable}, 32'd1);

        run(64, 20, 8, 1'b0);
        chk("edge64_stable", {31'b0, period_stable}, 32'd1);
        chk("edge64_period", period_1000, 32'd64000);
        run(65, 20, 4, 1'b0);
        chk("edge65_stable", {31'b0, period_stable}, 32'd0);

        for (int s = 0; s < 40; s++) begin
            p  = int'($urandom_range(2, 70));
            hi = int'($urandom_range(1, p - 1));
            run(p, hi, int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    cycle(1'($urandom_range(0, 1)), 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
